// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST controller: FSM states, pattern modes
// and the data pattern generator used by both the controller and its bench.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_t;

  typedef enum logic [1:0] {
    MODE_INCR     = 2'd0,
    MODE_BYTE_REP = 2'd1,
    MODE_INV      = 2'd2
  } bist_mode_t;

  // Patterns are generated at this width and truncated by the caller, so any
  // DATA_W up to PAT_W shares one definition.
  localparam int PAT_W = 256;
  localparam int IDX_W = 32;

  function automatic logic [PAT_W-1:0] bist_pattern(input logic [1:0]       mode,
                                                    input logic [PAT_W-1:0] seed,
                                                    input logic [IDX_W-1:0] idx);
    logic [PAT_W-1:0] sum;
    logic [7:0]       byte_val;
    sum      = seed + PAT_W'(idx);
    byte_val = seed[7:0] + idx[7:0];
    case (mode)
      MODE_BYTE_REP: bist_pattern = {(PAT_W/8){byte_val}};
      MODE_INV:      bist_pattern = ~sum;
      default:       bist_pattern = sum;  // mode 3 behaves as incrementing
    endcase
  endfunction

endpackage

// File: rtl/mem_bist_rd_pipe.sv
// Delay line carrying {valid, index, expected word} alongside an outstanding
// memory read so the compare lines up with the returning read data.
module mem_bist_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int IDX_W   = 10,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_exp,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_exp
);

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic              valid_reg;
      logic [IDX_W-1:0]  idx_reg;
      logic [DATA_W-1:0] exp_reg;
      logic              valid_prev;
      logic [IDX_W-1:0]  idx_prev;
      logic [DATA_W-1:0] exp_prev;

      if (gi == 0) begin : g_head
        assign valid_prev = in_valid;
        assign idx_prev   = in_idx;
        assign exp_prev   = in_exp;
      end else begin : g_link
        assign valid_prev = g_stage[gi-1].valid_reg;
        assign idx_prev   = g_stage[gi-1].idx_reg;
        assign exp_prev   = g_stage[gi-1].exp_reg;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          valid_reg <= 1'b0;
          idx_reg   <= '0;
          exp_reg   <= '0;
        end else begin
          valid_reg <= valid_prev;
          idx_reg   <= idx_prev;
          exp_reg   <= exp_prev;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[LATENCY-1].valid_reg;
  assign out_idx   = g_stage[LATENCY-1].idx_reg;
  assign out_exp   = g_stage[LATENCY-1].exp_reg;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes a seeded pattern over DEPTH words, reads it
// back, and reports mismatch count plus the first failing address/data.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 600,
  parameter int RD_LATENCY = 1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [DATA_W-1:0]    seed_i,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_we_o,
  output logic [DATA_W/8-1:0]  mem_be_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [ADDR_W-1:0]    err_addr_o,
  output logic [DATA_W-1:0]    err_exp_o,
  output logic [DATA_W-1:0]    err_act_o
);

  // One extra index bit so DEPTH == 2**ADDR_W terminates cleanly.
  localparam int                CNT_W    = ADDR_W + 1;
  localparam int                DRN_W    = 2;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [DRN_W-1:0]  LAST_DRN = DRN_W'(RD_LATENCY - 1);

  bist_state_t            state_reg;
  logic [CNT_W-1:0]       idx_reg;
  logic [CNT_W-1:0]       idx_next;
  logic [DRN_W-1:0]       drain_reg;
  logic [1:0]             mode_reg;
  logic [DATA_W-1:0]      seed_reg;

  logic [ADDR_W-1:0]      addr_reg;
  logic                   we_reg;
  logic [DATA_W/8-1:0]    be_reg;
  logic [DATA_W-1:0]      wdata_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   pass_reg;

  logic [ERR_CNT_W-1:0]   err_cnt_reg;
  logic [ADDR_W-1:0]      err_addr_reg;
  logic [DATA_W-1:0]      err_exp_reg;
  logic [DATA_W-1:0]      err_act_reg;

  logic                   start_accept;
  logic                   cmp_valid;
  logic [ADDR_W-1:0]      cmp_idx;
  logic [DATA_W-1:0]      cmp_exp;
  logic                   mismatch;

  function automatic logic [DATA_W-1:0] pat(input logic [1:0]        m,
                                            input logic [DATA_W-1:0] s,
                                            input logic [CNT_W-1:0]  i);
    return DATA_W'(bist_pattern(m, PAT_W'(s), IDX_W'(i)));
  endfunction

  assign idx_next     = idx_reg + 1'b1;
  assign start_accept = start_i && ((state_reg == IDLE) || (state_reg == DONE));

  mem_bist_rd_pipe #(
    .LATENCY (RD_LATENCY),
    .IDX_W   (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_rd_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (state_reg == READ),
    .in_idx    (idx_reg[ADDR_W-1:0]),
    .in_exp    (pat(mode_reg, seed_reg, idx_reg)),
    .out_valid (cmp_valid),
    .out_idx   (cmp_idx),
    .out_exp   (cmp_exp)
  );

  assign mismatch = cmp_valid && (mem_rdata_i != cmp_exp);

  // Outputs are registered together with the state so each cycle's memory
  // command matches the state/index the FSM is in during that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      drain_reg <= '0;
      mode_reg  <= '0;
      seed_reg  <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      be_reg    <= '0;
      wdata_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      pass_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start_i) begin
            state_reg <= WRITE;
            idx_reg   <= '0;
            mode_reg  <= mode_i;
            seed_reg  <= seed_i;
            addr_reg  <= '0;
            we_reg    <= 1'b1;
            be_reg    <= '1;
            wdata_reg <= pat(mode_i, seed_i, '0);
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            pass_reg  <= 1'b0;
          end
        end
        WRITE: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= READ;
            idx_reg   <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
          end else begin
            idx_reg   <= idx_next;
            addr_reg  <= idx_next[ADDR_W-1:0];
            wdata_reg <= pat(mode_reg, seed_reg, idx_next);
          end
        end
        READ: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= DRAIN;
            drain_reg <= '0;
            addr_reg  <= '0;
          end else begin
            idx_reg  <= idx_next;
            addr_reg <= idx_next[ADDR_W-1:0];
          end
        end
        DRAIN: begin
          if (drain_reg == LAST_DRN) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            // The final compare lands on this same edge.
            pass_reg  <= (err_cnt_reg == '0) && !mismatch;
          end else begin
            drain_reg <= drain_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_reg  <= '0;
      err_addr_reg <= '0;
      err_exp_reg  <= '0;
      err_act_reg  <= '0;
    end else if (start_accept) begin
      err_cnt_reg  <= '0;
      err_addr_reg <= '0;
      err_exp_reg  <= '0;
      err_act_reg  <= '0;
    end else if (mismatch) begin
      if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
      // Counter never wraps back to zero, so zero means "first in this run".
      if (err_cnt_reg == '0) begin
        err_addr_reg <= cmp_idx;
        err_exp_reg  <= cmp_exp;
        err_act_reg  <= mem_rdata_i;
      end
    end
  end

  assign mem_addr_o  = addr_reg;
  assign mem_we_o    = we_reg;
  assign mem_be_o    = be_reg;
  assign mem_wdata_o = wdata_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign pass_o      = pass_reg;
  assign err_cnt_o   = err_cnt_reg;
  assign err_addr_o  = err_addr_reg;
  assign err_exp_o   = err_exp_reg;
  assign err_act_o   = err_act_reg;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: three instances (default, latency 3 with a stuck-at-0
// memory, and a full-address-space 16-word instance) driven by tables and random runs.
module tb_mem_bist_ctrl;
  import mem_bist_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        start_q [NI];
  logic [1:0]  mode_q  [NI];
  logic [31:0] seed_q  [NI];

  // Instance A: defaults, ideal memory with optional read bit flips.
  logic [9:0]  a_addr;  logic a_we;  logic [3:0] a_be;  logic [31:0] a_wdata, a_rdata;
  logic a_busy, a_done, a_pass;
  logic [15:0] a_cnt;  logic [9:0] a_eaddr;  logic [31:0] a_exp, a_act;
  // Instance B: latency 3, memory reads constant zero.
  logic [9:0]  b_addr;  logic b_we;  logic [3:0] b_be;  logic [31:0] b_wdata, b_rdata;
  logic b_busy, b_done, b_pass;
  logic [15:0] b_cnt;  logic [9:0] b_eaddr;  logic [31:0] b_exp, b_act;
  // Instance C: 4-bit address, DEPTH 16, 16-bit data, latency 2, 3-bit counter.
  logic [3:0]  c_addr;  logic c_we;  logic [1:0] c_be;  logic [15:0] c_wdata, c_rdata;
  logic c_busy, c_done, c_pass;
  logic [2:0]  c_cnt;  logic [3:0] c_eaddr;  logic [15:0] c_exp, c_act;

  mem_bist_ctrl #(.ADDR_W(10), .DATA_W(32), .DEPTH(600), .RD_LATENCY(1), .ERR_CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_q[0]), .mode_i(mode_q[0]), .seed_i(seed_q[0]),
    .mem_addr_o(a_addr), .mem_we_o(a_we), .mem_be_o(a_be), .mem_wdata_o(a_wdata),
    .mem_rdata_i(a_rdata), .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
    .err_cnt_o(a_cnt), .err_addr_o(a_eaddr), .err_exp_o(a_exp), .err_act_o(a_act));

  mem_bist_ctrl #(.ADDR_W(10), .DATA_W(32), .DEPTH(600), .RD_LATENCY(3), .ERR_CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_q[1]), .mode_i(mode_q[1]), .seed_i(seed_q[1]),
    .mem_addr_o(b_addr), .mem_we_o(b_we), .mem_be_o(b_be), .mem_wdata_o(b_wdata),
    .mem_rdata_i(b_rdata), .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
    .err_cnt_o(b_cnt), .err_addr_o(b_eaddr), .err_exp_o(b_exp), .err_act_o(b_act));

  mem_bist_ctrl #(.ADDR_W(4), .DATA_W(16), .DEPTH(16), .RD_LATENCY(2), .ERR_CNT_W(3)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_q[2]), .mode_i(mode_q[2]), .seed_i(seed_q[2][15:0]),
    .mem_addr_o(c_addr), .mem_we_o(c_we), .mem_be_o(c_be), .mem_wdata_o(c_wdata),
    .mem_rdata_i(c_rdata), .busy_o(c_busy), .done_o(c_done), .pass_o(c_pass),
    .err_cnt_o(c_cnt), .err_addr_o(c_eaddr), .err_exp_o(c_exp), .err_act_o(c_act));

  // Memory models
  logic [31:0] mem_a [1024];
  logic [31:0] flip_a [1024];
  logic [31:0] rq_a;
  logic [15:0] mem_c [16];
  logic [15:0] flip_c [16];
  logic [15:0] rq_c1, rq_c2;

  always @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_wdata;
    rq_a <= mem_a[a_addr] ^ flip_a[a_addr];
    if (c_we) mem_c[c_addr] <= c_wdata;
    rq_c1 <= mem_c[c_addr] ^ flip_c[c_addr];
    rq_c2 <= rq_c1;
  end
  assign a_rdata = rq_a;
  assign b_rdata = '0;
  assign c_rdata = rq_c2;

  // Uniform 32-bit views so one run routine serves all instances.
  logic [31:0] v_addr [NI], v_wdata [NI], v_be [NI], v_cnt [NI], v_eaddr [NI], v_exp [NI], v_act [NI];
  logic        v_we [NI], v_busy [NI], v_done [NI], v_pass [NI];

  always_comb begin
    v_addr[0] = 32'(a_addr); v_wdata[0] = a_wdata; v_be[0] = 32'(a_be); v_cnt[0] = 32'(a_cnt);
    v_eaddr[0] = 32'(a_eaddr); v_exp[0] = a_exp; v_act[0] = a_act;
    v_we[0] = a_we; v_busy[0] = a_busy; v_done[0] = a_done; v_pass[0] = a_pass;
    v_addr[1] = 32'(b_addr); v_wdata[1] = b_wdata; v_be[1] = 32'(b_be); v_cnt[1] = 32'(b_cnt);
    v_eaddr[1] = 32'(b_eaddr); v_exp[1] = b_exp; v_act[1] = b_act;
    v_we[1] = b_we; v_busy[1] = b_busy; v_done[1] = b_done; v_pass[1] = b_pass;
    v_addr[2] = 32'(c_addr); v_wdata[2] = 32'(c_wdata); v_be[2] = 32'(c_be); v_cnt[2] = 32'(c_cnt);
    v_eaddr[2] = 32'(c_eaddr); v_exp[2] = 32'(c_exp); v_act[2] = 32'(c_act);
    v_we[2] = c_we; v_busy[2] = c_busy; v_done[2] = c_done; v_pass[2] = c_pass;
  end

  function automatic int depth_of(input int sel);
    return (sel == 2) ? 16 : 600;
  endfunction
  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 3 : 2);
  endfunction
  function automatic logic [31:0] dmask(input int sel);
    return (sel == 2) ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction
  function automatic int cnt_max(input int sel);
    return (sel == 2) ? 7 : 65535;
  endfunction

  // Reference pattern straight from the rules: sum, replicated byte, or inverted sum.
  function automatic logic [31:0] model_p(input int sel, input logic [1:0] mode,
                                          input logic [31:0] seed, input int i);
    logic [31:0] s;
    int          b;
    s = seed + 32'(i);
    b = (int'(seed % 256) + i) % 256;
    case (mode)
      2'd1:    s = 32'(b) * 32'h0101_0101;
      2'd2:    s = ~s;
      default: ;
    endcase
    return s & dmask(sel);
  endfunction

  function automatic logic [31:0] flip_of(input int sel, input int i);
    if (sel == 0) return flip_a[i];
    if (sel == 2) return 32'(flip_c[i]);
    return 32'h0;
  endfunction

  // What the memory returns for address i, assuming the write phase was correct.
  function automatic logic [31:0] model_read(input int sel, input logic [1:0] mode,
                                             input logic [31:0] seed, input int i);
    if (sel == 1) return 32'h0;
    return model_p(sel, mode, seed, i) ^ flip_of(sel, i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_flips(input int sel, input int addr, input logic [31:0] mask);
    for (int i = 0; i < 1024; i++) flip_a[i] = '0;
    for (int i = 0; i < 16; i++) flip_c[i] = '0;
    for (int i = 0; i < depth_of(sel); i++) begin
      if (addr == -2 || addr == i) begin
        if (sel == 0) flip_a[i] = mask;
        if (sel == 2) flip_c[i] = mask[15:0];
      end
    end
  endtask

  // Launch one test, follow it to done, and check every write as it happens.
  task automatic run_core(input int sel, input logic [1:0] mode, input logic [31:0] seed,
                          input bit poke, output int cycles, output int wr_bad, output int wr_cnt);
    int guard;
    @(negedge clk);
    mode_q[sel] = mode; seed_q[sel] = seed; start_q[sel] = 1'b1;
    @(negedge clk);
    start_q[sel] = 1'b0;
    cycles = 0; wr_bad = 0; wr_cnt = 0; guard = 0;
    while (!v_done[sel] && guard < 5000) begin
      if (v_busy[sel]) cycles++;
      if (v_we[sel]) begin
        if (v_addr[sel] != 32'(wr_cnt) || v_wdata[sel] != model_p(sel, mode, seed, wr_cnt) ||
            v_be[sel] != (dmask(sel) >> 28) && sel != 2 || (sel == 2 && v_be[sel] != 32'h3))
          wr_bad++;
        wr_cnt++;
      end
      if (poke && cycles == depth_of(sel) + 10) begin
        start_q[sel] = 1'b1; mode_q[sel] = ~mode; seed_q[sel] = ~seed;
      end else begin
        start_q[sel] = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    start_q[sel] = 1'b0;
    chk("finished_in_budget", 32'(guard < 5000), 32'h1);
    $display("[TB] run inst=%0d mode=%0d seed=0x%0h busy=%0d err_cnt=%0d pass=%0d err_addr=%0d",
             sel, mode, seed, cycles, v_cnt[sel], v_pass[sel], v_eaddr[sel]);
  endtask

  task automatic check_idle_outputs(input int sel);
    chk("idle_cmd_zero", v_addr[sel] | v_wdata[sel] | v_be[sel] | 32'(v_we[sel]), 32'h0);
  endtask

  // Random/regression run checked against the reference model.
  task automatic model_run(input int sel, input logic [1:0] mode, input logic [31:0] seed, input bit poke);
    int cycles, wr_bad, wr_cnt, n_err, first;
    logic [31:0] fe, fa, e, a;
    run_core(sel, mode, seed, poke, cycles, wr_bad, wr_cnt);
    n_err = 0; first = -1; fe = '0; fa = '0;
    for (int i = 0; i < depth_of(sel); i++) begin
      e = model_p(sel, mode, seed, i);
      a = model_read(sel, mode, seed, i);
      if (e != a) begin
        if (first < 0) begin first = i; fe = e; fa = a; end
        n_err++;
      end
    end
    chk("m_busy_cycles", 32'(cycles), 32'(2 * depth_of(sel) + lat_of(sel)));
    chk("m_done", 32'(v_done[sel]), 32'h1);
    chk("m_pass", 32'(v_pass[sel]), 32'(n_err == 0));
    chk("m_err_cnt", v_cnt[sel], 32'((n_err > cnt_max(sel)) ? cnt_max(sel) : n_err));
    chk("m_err_addr", v_eaddr[sel], (first < 0) ? 32'h0 : 32'(first));
    chk("m_err_exp", v_exp[sel], fe);
    chk("m_err_act", v_act[sel], fa);
    chk("m_write_data", 32'(wr_bad), 32'h0);
    chk("m_write_count", 32'(wr_cnt), 32'(depth_of(sel)));
    check_idle_outputs(sel);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] seed;
    int          idx;
    logic [31:0] exp;
  } pat_vec_t;

  typedef struct {
    int          sel;
    logic [1:0]  mode;
    logic [31:0] seed;
    int          flip_addr;   // -1 none, -2 every address
    logic [31:0] flip_mask;
    logic        exp_pass;
    int          exp_cnt;
    int          exp_eaddr;
    logic [31:0] exp_e;
    logic [31:0] exp_a;
    int          exp_cyc;
  } run_vec_t;

  pat_vec_t pv [8];
  run_vec_t rv [7];

  initial begin
    int cycles, wr_bad, wr_cnt, guard, nflip;
    logic [31:0] got;

    pv[0] = '{2'd0, 32'h0000_0000, 5,   32'h0000_0005};
    pv[1] = '{2'd1, 32'h0000_0000, 3,   32'h0303_0303};
    pv[2] = '{2'd1, 32'h0000_0000, 256, 32'h0000_0000};
    pv[3] = '{2'd2, 32'h0000_0000, 0,   32'hffff_ffff};
    pv[4] = '{2'd3, 32'h0000_000a, 1,   32'h0000_000b};
    pv[5] = '{2'd0, 32'hffff_ffff, 1,   32'h0000_0000};
    pv[6] = '{2'd1, 32'h1234_56fe, 3,   32'h0101_0101};
    pv[7] = '{2'd2, 32'h0000_0005, 2,   32'hffff_fff8};

    rv[0] = '{0, 2'd0, 32'h0,          -1,  32'h0,          1'b1, 0,   0,   32'h0,      32'h0,          1201};
    rv[1] = '{0, 2'd0, 32'h0,          5,   32'h1,          1'b0, 1,   5,   32'h5,      32'h4,          1201};
    rv[2] = '{1, 2'd0, 32'h0,          -1,  32'h0,          1'b0, 599, 1,   32'h1,      32'h0,          1203};
    rv[3] = '{2, 2'd2, 32'h1234,       15,  32'h8000,       1'b0, 1,   15,  32'hedbc,   32'h6dbc,       34};
    rv[4] = '{2, 2'd0, 32'h0,          -2,  32'h1,          1'b0, 7,   0,   32'h0,      32'h1,          34};
    rv[5] = '{0, 2'd1, 32'h0,          -1,  32'h0,          1'b1, 0,   0,   32'h0,      32'h0,          1201};
    rv[6] = '{0, 2'd3, 32'hffff_fff0,  599, 32'h8000_0000,  1'b0, 1,   599, 32'h247,    32'h8000_0247,  1201};

    for (int i = 0; i < NI; i++) begin start_q[i] = 1'b0; mode_q[i] = '0; seed_q[i] = '0; end
    set_flips(0, -1, 32'h0);

    repeat (3) @(negedge clk);
    chk("reset_outputs_a", 32'(|{a_addr, a_we, a_be, a_wdata, a_busy, a_done, a_pass,
                                 a_cnt, a_eaddr, a_exp, a_act}), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 32'({a_busy, b_busy, c_busy, a_done, b_done, c_done}), 32'h0);

    foreach (pv[k]) begin
      got = 32'(bist_pattern(pv[k].mode, PAT_W'(pv[k].seed), IDX_W'(pv[k].idx)));
      chk("pattern_fn", got, pv[k].exp);
    end

    foreach (rv[k]) begin
      set_flips(rv[k].sel, rv[k].flip_addr, rv[k].flip_mask);
      run_core(rv[k].sel, rv[k].mode, rv[k].seed, 1'b0, cycles, wr_bad, wr_cnt);
      chk("v_busy_cycles", 32'(cycles), 32'(rv[k].exp_cyc));
      chk("v_done", 32'(v_done[rv[k].sel]), 32'h1);
      chk("v_pass", 32'(v_pass[rv[k].sel]), 32'(rv[k].exp_pass));
      chk("v_err_cnt", v_cnt[rv[k].sel], 32'(rv[k].exp_cnt));
      chk("v_err_addr", v_eaddr[rv[k].sel], 32'(rv[k].exp_eaddr));
      chk("v_err_exp", v_exp[rv[k].sel], rv[k].exp_e);
      chk("v_err_act", v_act[rv[k].sel], rv[k].exp_a);
      chk("v_write_data", 32'(wr_bad), 32'h0);
      check_idle_outputs(rv[k].sel);
      if (k == 5) begin
        chk("byte_rep_addr3", mem_a[3], 32'h0303_0303);
        chk("byte_rep_addr256", mem_a[256], 32'h0000_0000);
      end
    end

    // Reset in the middle of the write phase.
    set_flips(0, -1, 32'h0);
    @(negedge clk);
    mode_q[0] = 2'd0; seed_q[0] = 32'h55; start_q[0] = 1'b1;
    @(negedge clk);
    start_q[0] = 1'b0;
    guard = 0;
    while (!(a_we && a_addr == 10'd100) && guard < 2000) begin
      guard++;
      @(negedge clk);
    end
    chk("reached_write_100", 32'(guard < 2000), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_reset_outputs", 32'(|{a_addr, a_we, a_be, a_wdata, a_busy, a_done, a_pass,
                                   a_cnt, a_eaddr, a_exp, a_act}), 32'h0);
    @(negedge clk);
    chk("mid_reset_hold", 32'(|{a_addr, a_we, a_busy, a_done, a_pass}), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_restart_without_start", 32'(a_busy), 32'h0);

    // Restart, with a stray start (new mode/seed) while busy; must be ignored.
    model_run(0, 2'd2, 32'h0bad_cafe, 1'b1);
    model_run(2, 2'd1, 32'h00a7, 1'b1);

    for (int r = 0; r < 3; r++) begin
      set_flips(0, -1, 32'h0);
      nflip = $urandom_range(3, 0);
      for (int f = 0; f < nflip; f++)
        flip_a[$urandom_range(599, 0)] = 32'h1 << $urandom_range(31, 0);
      model_run(0, 2'($urandom_range(3, 0)), $urandom, 1'b0);
    end
    for (int r = 0; r < 12; r++) begin
      set_flips(2, -1, 32'h0);
      nflip = $urandom_range(12, 0);
      for (int f = 0; f < nflip; f++)
        flip_c[$urandom_range(15, 0)] = 16'h1 << $urandom_range(15, 0);
      model_run(2, 2'($urandom_range(3, 0)), 32'($urandom_range(65535, 0)), 1'b0);
    end
    model_run(1, 2'd2, $urandom, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width; multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 600, number of words tested, 1..2^ADDR_W.
REQ-004 SHALL have parameter RD_LATENCY, default 1, memory read latency in cycles, 1..4.
REQ-005 SHALL have parameter ERR_CNT_W, default 16, error counter width.
REQ-006 SHALL have ports (one clock; reset is asynchronous and active-high):
 clk_i  in  1  system clock
 rst_i  in  1  asynchronous active-high reset
 start_i  in  1  launch test
 mode_i  in  2  pattern select
 seed_i  in  DATA_W  pattern start value
 mem_addr_o  out  ADDR_W  memory address
 mem_we_o  out  1  write enable
 mem_be_o  out  DATA_W/8  byte enables
 mem_wdata_o  out  DATA_W  write data
 mem_rdata_i  in  DATA_W  read data
 busy_o  out  1  test running
 done_o  out  1  test finished, results valid
 pass_o  out  1  no mismatch seen
 err_cnt_o  out  ERR_CNT_W  mismatch count
 err_addr_o  out  ADDR_W  first failing address
 err_exp_o  out  DATA_W  first failing expected word
 err_act_o  out  DATA_W  first failing read word

Function
REQ-007 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-008 SHALL leave IDLE or DONE for WRITE on the cycle after start_i=1; mode_i and seed_i latched at that edge; start_i ignored in all other states.
REQ-009 SHALL, in WRITE, drive mem_we_o=1, mem_be_o all ones, mem_addr_o=i, mem_wdata_o=P(i) for i=0..DEPTH-1, one word per cycle, then enter READ.
REQ-010 SHALL compute P(i): mode 0 INCR = seed+i mod 2^DATA_W; mode 1 BYTE_REP = seed[7:0]+i[7:0] replicated to every byte; mode 2 INV = ~(seed+i); mode 3 treated as mode 0.
REQ-011 SHALL, in READ, drive mem_we_o=0, mem_be_o=0, mem_addr_o=i for i=0..DEPTH-1, one per cycle, then enter DRAIN for RD_LATENCY cycles, then DONE.
REQ-012 SHALL compare mem_rdata_i exactly RD_LATENCY cycles after each read address is issued against P(i), using a RD_LATENCY-deep pipeline of valid, index and expected word.
REQ-013 SHALL, on mismatch, increment err_cnt_o saturating at all ones; on first mismatch of a run, capture err_addr_o, err_exp_o, err_act_o.
REQ-014 SHALL keep busy_o=1 in WRITE, READ, DRAIN: exactly 2*DEPTH+RD_LATENCY cycles.
REQ-015 SHALL hold done_o=1 and pass_o=(err_cnt_o==0) in DONE until next start; pass_o=0 whenever done_o=0.
REQ-016 SHALL clear err_cnt_o and error capture registers on entry to WRITE.
REQ-017 SHALL keep mem_addr_o=0, mem_wdata_o=0, mem_we_o=0, mem_be_o=0 in IDLE and DONE.
REQ-018 SHALL handle DEPTH=2^ADDR_W without address counter overflow corrupting termination (counter ADDR_W+1 bits).

Reset
REQ-019 SHALL, on rst_i=1 at any time including mid-test, enter IDLE asynchronously with all outputs 0 and the compare pipeline invalidated.
REQ-020 SHALL start a fresh test only after rst_i deasserts and a new start_i.

Structure
REQ-021 SHALL place the state enum and mode encodings (MODE_INCR, MODE_BYTE_REP, MODE_INV) in shared package mem_bist_pkg.
REQ-022 SHALL implement the pattern function P as a package function used by RTL and bench.
REQ-023 SHALL implement the compare delay line as sub-module mem_bist_rd_pipe.

Verification
REQ-024 Ideal memory, latency 1, DEPTH 600, mode INCR, seed 0 -> busy 1201 cycles, done=1, pass=1, err_cnt=0.
REQ-025 Memory model flips bit 0 of addr 5 on read, mode INCR, seed 0 -> pass=0, err_cnt=1, err_addr=5, err_exp=0x5, err_act=0x4.
REQ-026 Mode BYTE_REP, seed 0 -> write at addr 3 carries 0x03030303, addr 256 carries 0x00000000; run passes.
REQ-027 RD_LATENCY=3, memory returning constant 0, mode INCR, seed 0 -> err_cnt=599, err_addr=1, err_exp=0x1, err_act=0x0.
REQ-028 rst_i pulsed at WRITE addr 100 -> all outputs 0 next cycle; start_i during busy ignored; restarted run passes.
